// File: rtl/pll_cfg_ctrl.sv
// PLL configuration controller: bypasses and powers down the PLL, loads the
// M/N/P divider codes over three four-phase handshakes, powers the PLL back up,
// waits for lock and then releases bypass. All outputs come from flops.
module pll_cfg_ctrl #(
  parameter int unsigned PD_CYCLES    = 16,
  parameter int unsigned ACK_TIMEOUT  = 255,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [16:0] cfg_mdec,
  input  logic [9:0]  cfg_ndec,
  input  logic [6:0]  cfg_pdec,
  output logic [16:0] mdec,
  output logic [9:0]  ndec,
  output logic [6:0]  pdec,
  output logic        mreq,
  output logic        nreq,
  output logic        preq,
  input  logic        mack,
  input  logic        nack,
  input  logic        pack,
  input  logic        lock,
  output logic        pd,
  output logic        bypass,
  output logic        busy,
  output logic        locked,
  output logic [1:0]  err
);

  localparam int unsigned MaxTo  = (LOCK_TIMEOUT > ACK_TIMEOUT) ? LOCK_TIMEOUT : ACK_TIMEOUT;
  localparam int unsigned MaxCnt = (MaxTo > PD_CYCLES) ? MaxTo : PD_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [1:0] ErrNone = 2'd0;
  localparam logic [1:0] ErrAck  = 2'd1;
  localparam logic [1:0] ErrLock = 2'd2;

  typedef enum logic [3:0] {
    StIdle, StByp, StPd, StLmReq, StLmRel, StLnReq, StLnRel,
    StLpReq, StLpRel, StPu, StWl, StRun, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       elapsed;
  logic              accept;

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic mack_s, nack_s, pack_s, lock_s;

  logic [16:0] mdec_q, mdec_d;
  logic [9:0]  ndec_q, ndec_d;
  logic [6:0]  pdec_q, pdec_d;
  logic        pd_q, pd_d, bypass_q, bypass_d;
  logic        mreq_q, mreq_d, nreq_q, nreq_d, preq_q, preq_d;
  logic        busy_q, busy_d, locked_q, locked_d, ready_q, ready_d;
  logic [1:0]  err_q, err_d;

  // Synchronize the PLL's asynchronous ack and lock pins
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {lock, pack, nack, mack}};
    end
  end

  assign {lock_s, pack_s, nack_s, mack_s} = sync_q[SYNC_STAGES-1];

  assign accept  = cfg_valid && ready_q;
  // Cycles spent in the current state, counting the present one
  assign elapsed = 32'(cnt_q) + 32'd1;

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mdec_q   <= '0;
      ndec_q   <= '0;
      pdec_q   <= '0;
      pd_q     <= 1'b1;
      bypass_q <= 1'b1;
      mreq_q   <= 1'b0;
      nreq_q   <= 1'b0;
      preq_q   <= 1'b0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= ErrNone;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mdec_q   <= mdec_d;
      ndec_q   <= ndec_d;
      pdec_q   <= pdec_d;
      pd_q     <= pd_d;
      bypass_q <= bypass_d;
      mreq_q   <= mreq_d;
      nreq_q   <= nreq_d;
      preq_q   <= preq_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  // Next-state sequencing; an arriving ack wins over a same-cycle timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StByp;
      StByp:   state_d = StPd;
      StPd:    if (elapsed >= PD_CYCLES) state_d = StLmReq;
      StLmReq: begin
        if (mack_s) state_d = StLmRel;
        else if (elapsed >= ACK_TIMEOUT) state_d = StErr;
      end
      StLmRel: begin
        if (!mack_s) state_d = StLnReq;
        else if (elapsed >= ACK_TIMEOUT) state_d = StErr;
      end
      StLnReq: begin
        if (nack_s) state_d = StLnRel;
        else if (elapsed >= ACK_TIMEOUT) state_d = StErr;
      end
      StLnRel: begin
        if (!nack_s) state_d = StLpReq;
        else if (elapsed >= ACK_TIMEOUT) state_d = StErr;
      end
      StLpReq: begin
        if (pack_s) state_d = StLpRel;
        else if (elapsed >= ACK_TIMEOUT) state_d = StErr;
      end
      StLpRel: begin
        if (!pack_s) state_d = StPu;
        else if (elapsed >= ACK_TIMEOUT) state_d = StErr;
      end
      StPu:    state_d = StWl;
      StWl: begin
        if (lock_s) state_d = StRun;
        else if (elapsed >= LOCK_TIMEOUT) state_d = StErr;
      end
      StRun: begin
        if (accept) state_d = StByp;
        else if (!lock_s) state_d = StWl;
      end
      StErr:   if (!mack_s && !nack_s && !pack_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output next values decoded from the state being entered
  always_comb begin
    pd_d     = 1'b1;
    bypass_d = 1'b1;
    mreq_d   = 1'b0;
    nreq_d   = 1'b0;
    preq_d   = 1'b0;
    busy_d   = 1'b1;
    locked_d = 1'b0;
    ready_d  = 1'b0;
    unique case (state_d)
      StIdle: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      StByp:   pd_d = pd_q;
      StLmReq: mreq_d = 1'b1;
      StLnReq: nreq_d = 1'b1;
      StLpReq: preq_d = 1'b1;
      StPu, StWl: pd_d = 1'b0;
      StRun: begin
        pd_d     = 1'b0;
        bypass_d = 1'b0;
        busy_d   = 1'b0;
        locked_d = 1'b1;
        ready_d  = 1'b1;
      end
      StErr:   busy_d = 1'b0;
      default: ;
    endcase

    // Counter restarts on every state change and saturates otherwise
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    mdec_d = mdec_q;
    ndec_d = ndec_q;
    pdec_d = pdec_q;
    err_d  = err_q;
    if (accept) begin
      mdec_d = cfg_mdec;
      ndec_d = cfg_ndec;
      pdec_d = cfg_pdec;
      err_d  = ErrNone;
    end else if (state_d == StErr && state_q != StErr) begin
      err_d = (state_q == StWl) ? ErrLock : ErrAck;
    end
  end

  assign mdec      = mdec_q;
  assign ndec      = ndec_q;
  assign pdec      = pdec_q;
  assign pd        = pd_q;
  assign bypass    = bypass_q;
  assign mreq      = mreq_q;
  assign nreq      = nreq_q;
  assign preq      = preq_q;
  assign busy      = busy_q;
  assign locked    = locked_q;
  assign cfg_ready = ready_q;
  assign err       = err_q;

endmodule
